// File: rtl/mem_access_unit.sv
// Load/store stage: one memory op per handshake, ready/valid data-memory port, extended load result.
// Optional macro MEM_ACCESS_UNALIGNED_EN enables lwl/lwr/swl/swr; without it ops 010/110 are illegal.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  output logic        MemRead,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_wen,
  output logic        resp_err
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t      r_state, w_next;
  logic        r_store;
  logic [2:0]  r_op;
  logic [1:0]  r_lo;
  logic [31:0] r_address, r_write_data, r_resp_data;
  logic [3:0]  r_write_strb;
  logic        r_resp_wen, r_resp_err;
  logic        w_req_err;
`ifdef MEM_ACCESS_UNALIGNED_EN
  logic [31:0] r_rt_old;
`else
  logic        w_unused_rt;
  assign w_unused_rt = &{1'b0, req_rt_old};
`endif

  function automatic logic f_legal(input logic st, input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b011: f_legal = 1'b1;
      3'b100, 3'b101:         f_legal = !st;
`ifdef MEM_ACCESS_UNALIGNED_EN
      3'b010, 3'b110:         f_legal = 1'b1;
`endif
      default:                f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b001, 3'b101: f_misaligned = a[0];
      3'b011:         f_misaligned = (a != 2'b00);
      default:        f_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rt);
    case (op)
      3'b000:  f_store_data = {4{rt[7:0]}};
      3'b001:  f_store_data = {2{rt[15:0]}};
      3'b011:  f_store_data = rt;
`ifdef MEM_ACCESS_UNALIGNED_EN
      3'b010:  f_store_data = rt >> {~a, 3'b000};
      3'b110:  f_store_data = rt << {a, 3'b000};
`endif
      default: f_store_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] f_store_strb(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000:  f_store_strb = 4'b0001 << a;
      3'b001:  f_store_strb = 4'b0011 << a;
      3'b011:  f_store_strb = 4'b1111;
`ifdef MEM_ACCESS_UNALIGNED_EN
      3'b010:  f_store_strb = 4'b1111 >> (~a);
      3'b110:  f_store_strb = 4'b1111 << a;
`endif
      default: f_store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] mem);
    logic [31:0] sh;
    logic [15:0] hw;
    sh = mem >> {a, 3'b000};
    hw = a[1] ? mem[31:16] : mem[15:0];
    case (op)
      3'b000:  f_load = {{24{sh[7]}}, sh[7:0]};
      3'b100:  f_load = {24'h00_0000, sh[7:0]};
      3'b001:  f_load = {{16{hw[15]}}, hw};
      3'b101:  f_load = {16'h0000, hw};
      3'b011:  f_load = mem;
      default: f_load = 32'h0000_0000;
    endcase
  endfunction

`ifdef MEM_ACCESS_UNALIGNED_EN
  // Left/right partial-word merges of the memory word into the old rt value.
  function automatic logic [31:0] f_merge(input logic left, input logic [1:0] a, input logic [31:0] mem, input logic [31:0] rt);
    case ({left, a})
      3'b100:  f_merge = {mem[7:0], rt[23:0]};
      3'b101:  f_merge = {mem[15:0], rt[15:0]};
      3'b110:  f_merge = {mem[23:0], rt[7:0]};
      3'b111:  f_merge = mem;
      3'b000:  f_merge = mem;
      3'b001:  f_merge = {rt[31:24], mem[31:8]};
      3'b010:  f_merge = {rt[31:16], mem[31:16]};
      3'b011:  f_merge = {rt[31:8], mem[31:24]};
      default: f_merge = 32'h0000_0000;
    endcase
  endfunction
`endif

  assign w_req_err = !f_legal(req_store, req_op) || f_misaligned(req_op, req_addr[1:0]);

  // Next-state and handshake decode.
  always_comb begin
    w_next          = r_state;
    req_ready       = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    Read_data_Ready = 1'b0;
    resp_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? S_RESP : S_REQ;
        else           w_next = S_IDLE;
      end
      S_REQ: begin
        MemRead  = !r_store;
        MemWrite = r_store;
        if (Mem_Req_Ready) w_next = r_store ? S_RESP : S_WAIT;
        else               w_next = S_REQ;
      end
      S_WAIT: begin
        Read_data_Ready = 1'b1;
        if (Read_data_Valid) w_next = S_RESP;
        else                 w_next = S_WAIT;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
        else            w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latch, memory-port and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_store      <= 1'b0;
      r_op         <= 3'b000;
      r_lo         <= 2'b00;
      r_address    <= 32'h0000_0000;
      r_write_data <= 32'h0000_0000;
      r_write_strb <= 4'b0000;
      r_resp_data  <= 32'h0000_0000;
      r_resp_wen   <= 1'b0;
      r_resp_err   <= 1'b0;
`ifdef MEM_ACCESS_UNALIGNED_EN
      r_rt_old     <= 32'h0000_0000;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store      <= req_store;
            r_op         <= req_op;
            r_lo         <= req_addr[1:0];
            r_address    <= {req_addr[31:2], 2'b00};
            r_resp_err   <= w_req_err;
            r_resp_wen   <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
            r_write_data <= (req_store && !w_req_err) ? f_store_data(req_op, req_addr[1:0], req_wdata) : 32'h0000_0000;
            r_write_strb <= (req_store && !w_req_err) ? f_store_strb(req_op, req_addr[1:0]) : 4'b0000;
`ifdef MEM_ACCESS_UNALIGNED_EN
            r_rt_old     <= req_rt_old;
`endif
          end
        end
        S_WAIT: begin
          if (Read_data_Valid) begin
            r_resp_wen <= 1'b1;
`ifdef MEM_ACCESS_UNALIGNED_EN
            if (r_op == 3'b010 || r_op == 3'b110)
              r_resp_data <= f_merge(r_op == 3'b010, r_lo, Read_data, r_rt_old);
            else
              r_resp_data <= f_load(r_op, r_lo, Read_data);
`else
            r_resp_data <= f_load(r_op, r_lo, Read_data);
`endif
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_data  <= 32'h0000_0000;
            r_resp_wen   <= 1'b0;
            r_resp_err   <= 1'b0;
            r_write_strb <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign Address    = r_address;
  assign Write_data = r_write_data;
  assign Write_strb = r_write_strb;
  assign resp_data  = r_resp_data;
  assign resp_wen   = r_resp_wen;
  assign resp_err   = r_resp_err;
endmodule
